// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED PIO control path: FSM encoding, PIO register map
// and the reset value the PIO slave powers up with.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [1:0]  PIO_DATA_ADDR   = 2'd0;
  localparam logic [31:0] LED_RESET_VALUE = 32'h0000FFFF;

endpackage

// File: rtl/led_pio_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr, so the last
// winner has the lowest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic found;
  int   cand;

  // first requester found walking (ptr+1) .. ptr wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/led_pio_write_arbiter.sv
// Shares the LED PIO data register among several requesters: each accepted
// request is merged into a shadow copy under its mask and written as one strobe.
module led_pio_write_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] RESET_VALUE = LED_RESET_VALUE,
  parameter int          MIN_GAP     = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*DATA_W-1:0]  req_mask,
  output logic [1:0]                 avm_address,
  output logic                       avm_chipselect,
  output logic                       avm_write_n,
  output logic [31:0]                avm_writedata,
  output logic [DATA_W-1:0]          shadow,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int         IW       = $clog2(NUM_REQ);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_WRITE  = WRITE;
  localparam logic [1:0] S_GAP    = GAP;
  localparam logic [7:0] GAP_LAST = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

  logic [1:0]        state;
  logic [IW-1:0]     ptr;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        gap_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]     arb_idx;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] sel_mask;
  logic [DATA_W-1:0] merged;
  logic [31:0]       merged_ext;

  function automatic logic [DATA_W-1:0] merge_bits(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [DATA_W-1:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // winner's word merged into the shadow, zero-extended onto the 32-bit bus
  always_comb begin
    sel_data   = req_data[arb_idx*DATA_W +: DATA_W];
    sel_mask   = req_mask[arb_idx*DATA_W +: DATA_W];
    merged     = merge_bits(shadow, sel_data, sel_mask);
    merged_ext = 32'd0;
    merged_ext[DATA_W-1:0] = merged;
  end

  // accept pulse is only offered while idle
  always_comb begin
    if (state == S_IDLE) begin
      req_ready = arb_grant;
    end else begin
      req_ready = '0;
    end
  end

  assign busy        = (state != S_IDLE);
  assign avm_address = PIO_DATA_ADDR;

  // FSM, shadow update and gap counter; strobe outputs are registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      ptr            <= IW'(NUM_REQ - 1);
      grant_id       <= '0;
      wdata          <= '0;
      shadow         <= RESET_VALUE[DATA_W-1:0];
      gap_cnt        <= 8'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            wdata          <= merged;
            avm_writedata  <= merged_ext;
            ptr            <= arb_idx;
            grant_id       <= arb_idx;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          shadow         <= wdata;
          gap_cnt        <= 8'd0;
          state          <= (MIN_GAP > 0) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state          <= S_IDLE;
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Directed bench: expected strobes are queued by the stimulus and checked by a
// negedge monitor; a second instance with MIN_GAP=3 covers gap spacing.
module tb_led_pio_write_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [127:0] req_mask;
  logic [1:0]   avm_address;
  logic         avm_chipselect;
  logic         avm_write_n;
  logic [31:0]  avm_writedata;
  logic [31:0]  shadow;
  logic [1:0]   grant_id;
  logic         busy;

  logic [3:0]   g_valid;
  logic [3:0]   g_ready;
  logic [127:0] g_data;
  logic [127:0] g_mask;
  logic [1:0]   g_address;
  logic         g_chipselect;
  logic         g_write_n;
  logic [31:0]  g_writedata;
  logic [31:0]  g_shadow;
  logic [1:0]   g_grant_id;
  logic         g_busy;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  led_pio_write_arbiter #(.NUM_REQ(4), .DATA_W(32), .RESET_VALUE(32'h0000FFFF), .MIN_GAP(0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .shadow(shadow), .grant_id(grant_id), .busy(busy)
  );

  led_pio_write_arbiter #(.NUM_REQ(4), .DATA_W(32), .RESET_VALUE(32'h0000FFFF), .MIN_GAP(3)) dut_gap (
    .clk(clk), .reset_n(reset_n), .req_valid(g_valid), .req_ready(g_ready),
    .req_data(g_data), .req_mask(g_mask), .avm_address(g_address),
    .avm_chipselect(g_chipselect), .avm_write_n(g_write_n),
    .avm_writedata(g_writedata), .shadow(g_shadow), .grant_id(g_grant_id), .busy(g_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] m);
    req_data[i*32 +: 32] = d;
    req_mask[i*32 +: 32] = m;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [31:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 4'd0;
    req_data  = '0;
    req_mask  = '0;
    g_valid   = 4'd0;
    g_data    = '0;
    g_mask    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // scoreboard monitor: every strobe of the main instance must match the queue head
  always @(negedge clk) begin
    if (reset_n === 1'b1 && avm_chipselect === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe", {27'd0, avm_address, avm_write_n, grant_id, avm_writedata},
                      {27'd0, 2'd0, 1'b0, e.id, e.data});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cs_cnt;
    int rdy_cnt;
    logic [15:0] rdy_vec;
    logic [15:0] busy_vec;

    // 1: reset state and quiet period
    reset_n   = 1'b0;
    req_valid = 4'd0;
    req_data  = '0;
    req_mask  = '0;
    g_valid   = 4'd0;
    g_data    = '0;
    g_mask    = '0;
    @(negedge clk);
    chk("reset_outputs", {26'd0, req_ready, avm_chipselect, avm_write_n, busy, grant_id, avm_writedata},
                         {26'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0});
    chk("reset_shadow", {32'd0, shadow}, {32'd0, 32'h0000FFFF});
    step();
    reset_n = 1'b1;
    cs_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) cs_cnt++;
    end
    chk("idle_no_strobe", 64'(cs_cnt), 64'd0);
    chk("idle_shadow", {32'd0, shadow}, {32'd0, 32'h0000FFFF});

    // 2: single request from requester 1, latency T / T+1 / T+2
    step();
    set_req(1, 32'h000000A5, 32'h000000FF);
    req_valid = 4'b0010;
    push_exp(2'd1, 32'h0000FFA5);
    @(negedge clk);
    chk("t2_ready", {60'd0, req_ready}, {60'd0, 4'b0010});
    step();
    req_valid = 4'd0;
    @(negedge clk);
    chk("t2_strobe_t1", {62'd0, avm_chipselect, busy}, {62'd0, 1'b1, 1'b1});
    step();
    @(negedge clk);
    chk("t2_shadow", {32'd0, shadow}, {32'd0, 32'h0000FFA5});

    // 3: all four requesters, disjoint nibbles, round-robin
    do_reset();
    set_req(0, 32'h12345678, 32'h0000000F);
    set_req(1, 32'h87654321, 32'h000000F0);
    set_req(2, 32'hCAFEBABE, 32'h00000F00);
    set_req(3, 32'hDEADBEEF, 32'h0000F000);
    push_exp(2'd0, 32'h0000FFF8);
    push_exp(2'd1, 32'h0000FF28);
    push_exp(2'd2, 32'h0000FA28);
    push_exp(2'd3, 32'h0000BA28);
    push_exp(2'd0, 32'h0000BA28);
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 2 == 0)
        chk($sformatf("t3_ready_%0d", k), {60'd0, req_ready}, {60'd0, 4'(4'b0001 << ((k / 2) % 4))});
      else
        chk($sformatf("t3_idle_ready_%0d", k), {59'd0, req_ready, avm_chipselect}, {59'd0, 4'd0, 1'b1});
      step();
      if (k == 8) req_valid = 4'd0;
    end
    @(negedge clk);
    chk("t3_shadow", {32'd0, shadow}, {32'd0, 32'h0000BA28});

    // 4: MIN_GAP=3 instance, requester 0 held valid
    do_reset();
    g_data[31:0] = 32'h000000C3;
    g_mask[31:0] = 32'h000000FF;
    g_valid      = 4'b0001;
    rdy_vec  = 16'd0;
    busy_vec = 16'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rdy_vec[k]  = g_ready[0];
      busy_vec[k] = g_busy;
      if (k == 1) chk("t4_strobe", {31'd0, g_chipselect, g_writedata}, {31'd0, 1'b1, 32'h0000FFC3});
      step();
    end
    g_valid = 4'd0;
    chk("t4_accept_spacing", {48'd0, rdy_vec}, {48'd0, 16'h8421});
    chk("t4_busy_pattern", {48'd0, busy_vec}, {48'd0, 16'h7BDE});
    repeat (6) step();

    // 5: reset during WRITE
    do_reset();
    set_req(1, 32'h00000000, 32'hFFFFFFFF);
    req_valid = 4'b0010;
    push_exp(2'd1, 32'h00000000);
    @(negedge clk);
    chk("t5_ready", {60'd0, req_ready}, {60'd0, 4'b0010});
    step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_reset_midwrite", {61'd0, avm_chipselect, avm_write_n, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
    chk("t5_reset_shadow", {32'd0, shadow}, {32'd0, 32'h0000FFFF});
    step();
    req_valid = 4'd0;
    reset_n   = 1'b1;
    set_req(0, 32'h00000000, 32'h0000000F);
    req_valid = 4'b0011;
    push_exp(2'd0, 32'h0000FFF0);
    @(negedge clk);
    chk("t5_first_grant", {60'd0, req_ready}, {60'd0, 4'b0001});
    step();
    req_valid = 4'd0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_shadow", {32'd0, shadow}, {32'd0, 32'h0000FFF0});

    // 6: zero mask still writes and acknowledges once
    step();
    set_req(2, 32'hFFFFFFFF, 32'h00000000);
    req_valid = 4'b0100;
    push_exp(2'd2, 32'h0000FFF0);
    @(negedge clk);
    chk("t6_ready", {60'd0, req_ready}, {60'd0, 4'b0100});
    step();
    req_valid = 4'd0;
    cs_cnt  = 0;
    rdy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (avm_chipselect === 1'b1) cs_cnt++;
      if (req_ready[2] === 1'b1) rdy_cnt++;
      step();
    end
    chk("t6_one_strobe", 64'(cs_cnt), 64'd1);
    chk("t6_no_extra_ready", 64'(rdy_cnt), 64'd0);
    chk("t6_shadow", {32'd0, shadow}, {32'd0, 32'h0000FFF0});

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
